// File: rtl/argmax_stream_feeder.sv
// argmax_stream_feeder: buffers one score vector from a valid/ready source and
// replays it as an indexed element stream, followed by a one-cycle flush bubble.
module argmax_stream_feeder #(
  parameter int DATA_WIDTH    = 8,
  parameter int INDEX_WIDTH   = 10,
  parameter int VECTOR_LENGTH = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [DATA_WIDTH-1:0]  in_value,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [INDEX_WIDTH-1:0] input_index,
  output logic [DATA_WIDTH-1:0]  input_value,
  output logic                   input_enable,
  output logic                   vector_done
);
  localparam int AW = $clog2(VECTOR_LENGTH);
  localparam logic [INDEX_WIDTH-1:0] LAST = INDEX_WIDTH'(VECTOR_LENGTH - 1);
  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;
  state_t state;
  logic [INDEX_WIDTH-1:0] fill_cnt, str_cnt;
  logic [DATA_WIDTH-1:0] mem [VECTOR_LENGTH];
  logic accept;
  assign accept = (state == FILL) && in_valid && in_ready;
  always_ff @(posedge clk)
    if (accept) mem[fill_cnt[AW-1:0]] <= in_value;
  // Element 0 is launched on the final accept edge so the stream starts one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= FILL;
      fill_cnt     <= '0;
      str_cnt      <= '0;
      in_ready     <= 1'b0;
      input_index  <= '0;
      input_value  <= '0;
      input_enable <= 1'b0;
      vector_done  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          vector_done  <= 1'b0;
          input_enable <= 1'b0;
          in_ready     <= 1'b1;
          if (accept) begin
            if (fill_cnt == LAST) begin
              fill_cnt     <= '0;
              in_ready     <= 1'b0;
              input_enable <= 1'b1;
              input_index  <= '0;
              input_value  <= mem[0];
              str_cnt      <= INDEX_WIDTH'(1);
              state        <= STREAM;
            end else begin
              fill_cnt <= fill_cnt + 1'b1;
            end
          end
        end
        STREAM: begin
          input_enable <= 1'b1;
          input_index  <= str_cnt;
          input_value  <= mem[str_cnt[AW-1:0]];
          str_cnt      <= (str_cnt == LAST) ? '0 : str_cnt + 1'b1;
          state        <= (str_cnt == LAST) ? FLUSH : STREAM;
        end
        FLUSH: begin
          input_enable <= 1'b0;
          input_index  <= '0;
          input_value  <= '0;
          vector_done  <= 1'b1;
          in_ready     <= 1'b0;
          state        <= FILL;
        end
        default: state <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_argmax_stream_feeder.sv
// tb_argmax_stream_feeder: table-driven cycle checks of the feeder's fill/stream/flush
// sequence, plus hand-written reset-abort and back-to-back sequences.
module tb_argmax_stream_feeder;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [7:0] in_value = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [9:0] input_index;
  logic [7:0] input_value;
  logic input_enable, vector_done;
  int n_chk = 0;
  int n_fail = 0;
  int cyc_n = 0;
  int done_q[$];
  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic       en;
    logic [9:0] idx;
    logic [7:0] val;
    logic       done;
  } row_t;
  row_t tbl[$];
  logic [7:0] va[10] = '{8'd3, 8'd7, 8'd1, 8'd9, 8'd9, 8'd0, 8'd2, 8'd8, 8'd5, 8'd4};
  logic [7:0] vb[10] = '{8'd200, 8'd17, 8'd255, 8'd1, 8'd0, 8'd128, 8'd64, 8'd33, 8'd99, 8'd254};
  logic [7:0] vc[10] = '{8'd5, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10, 8'd11, 8'd12, 8'd13, 8'd14};
  logic [7:0] vd[10] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100};

  argmax_stream_feeder #(.DATA_WIDTH(8), .INDEX_WIDTH(10), .VECTOR_LENGTH(10)) dut (
    .clk(clk), .reset_n(reset_n), .in_value(in_value), .in_valid(in_valid),
    .in_ready(in_ready), .input_index(input_index), .input_value(input_value),
    .input_enable(input_enable), .vector_done(vector_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
    if (vector_done === 1'b1) done_q.push_back(cyc_n);
  endtask

  task automatic chk_outs(input string tag, input logic rdy, input logic en, input logic [9:0] idx,
                          input logic [7:0] val, input logic done);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
    chk({tag, ".input_enable"}, 32'(input_enable), 32'(en));
    chk({tag, ".input_index"}, 32'(input_index), 32'(idx));
    chk({tag, ".input_value"}, 32'(input_value), 32'(val));
    chk({tag, ".vector_done"}, 32'(vector_done), 32'(done));
  endtask

  // Expected outputs after each clock edge, for one full vector period starting with in_ready=1.
  task automatic run_vector(input string tag, input logic [7:0] v[10], input bit toggle, input bit junk);
    tbl.delete();
    for (int i = 0; i < 10; i++) begin
      if (toggle && i > 0) tbl.push_back('{1'b0, 8'h55, 1'b1, 1'b0, 10'd0, 8'd0, 1'b0});
      tbl.push_back('{1'b1, v[i], i < 9, i == 9, 10'd0, (i == 9) ? v[0] : 8'd0, 1'b0});
    end
    for (int k = 1; k < 10; k++)
      tbl.push_back('{junk, junk ? 8'hFF : 8'h00, 1'b0, 1'b1, 10'(k), v[k], 1'b0});
    tbl.push_back('{junk, 8'hFF, 1'b0, 1'b0, 10'd0, 8'd0, 1'b1});
    tbl.push_back('{junk, 8'hFF, 1'b1, 1'b0, 10'd0, 8'd0, 1'b0});
    foreach (tbl[r]) begin
      in_valid = tbl[r].v;
      in_value = tbl[r].d;
      cyc();
      chk_outs($sformatf("%s.row%0d", tag, r), tbl[r].rdy, tbl[r].en, tbl[r].idx, tbl[r].val, tbl[r].done);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1 reset_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk_outs($sformatf("reset%0d", i), 1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    end
    reset_n = 1'b1;
    cyc();
    chk_outs("release", 1'b1, 1'b0, 10'd0, 8'd0, 1'b0);

    run_vector("vecA", va, 1'b0, 1'b0);
    run_vector("vecA_toggle", va, 1'b1, 1'b0);
    run_vector("vecB_junk", vb, 1'b0, 1'b1);
    run_vector("vecC_after_junk", vc, 1'b0, 1'b0);

    // Abort on stream element 4: no vector_done, next vector restarts from index 0.
    done_q.delete();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_value = 8'(i + 1);
      cyc();
    end
    in_valid = 1'b0;
    repeat (4) cyc();
    chk("abort.pre_index", 32'(input_index), 32'd4);
    chk("abort.pre_value", 32'(input_value), 32'd5);
    chk("abort.pre_enable", 32'(input_enable), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk_outs("abort.async", 1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    repeat (2) begin
      cyc();
      chk_outs("abort.held", 1'b0, 1'b0, 10'd0, 8'd0, 1'b0);
    end
    #2 reset_n = 1'b1;
    cyc();
    chk_outs("abort.release", 1'b1, 1'b0, 10'd0, 8'd0, 1'b0);
    chk("abort.no_done", 32'(done_q.size()), 32'd0);
    run_vector("vecC_after_abort", vc, 1'b0, 1'b0);

    // Back-to-back with in_valid held high throughout.
    done_q.delete();
    run_vector("b2b_1", va, 1'b0, 1'b1);
    run_vector("b2b_2", vd, 1'b0, 1'b0);
    chk("b2b.done_count", 32'(done_q.size()), 32'd2);
    if (done_q.size() == 2) chk("b2b.done_spacing", 32'(done_q[1] - done_q[0]), 32'd21);
    else chk("b2b.done_spacing", 32'(done_q.size()), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/argmax_stream_feeder.md
Name: argmax_stream_feeder

Overview:
- Producer for the argmax cell chain. Accepts one score vector of VECTOR_LENGTH elements from an upstream valid/ready source, such as the output layer accumulator, and buffers it.
- Replays the buffered vector as the (input_index, input_value, input_enable) stream that argmax_cell consumes: one element per cycle, indices 0..VECTOR_LENGTH-1.
- After each vector it inserts a one-cycle flush bubble and pulses vector_done, so the argmax chain sees clean vector boundaries.

Parameters:
- DATA_WIDTH, 8, width of each score value.
- INDEX_WIDTH, 10, width of the emitted index. Must satisfy 2**INDEX_WIDTH >= VECTOR_LENGTH.
- VECTOR_LENGTH, 10, number of elements per vector. Minimum 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_value  input  DATA_WIDTH  upstream score element.
- in_valid  input  1  upstream element valid.
- in_ready  output  1  feeder can accept an element this cycle.
- input_index  output  INDEX_WIDTH  element index to the argmax chain.
- input_value  output  DATA_WIDTH  element value to the argmax chain.
- input_enable  output  1  high while input_index/input_value carry a real element.
- vector_done  output  1  one-cycle pulse on the flush bubble after the last element of a vector.

Behaviour:
- All outputs are registered.
- Reset (reset_n low, asynchronous):
  - state=FILL, fill and stream counters=0.
  - in_ready=0, input_index=0, input_value=0, input_enable=0, vector_done=0.
  - in_ready rises on the first clock edge after reset is released.
  - Buffer contents are don't-care.
- State FILL:
  - in_ready=1.
  - Each cycle with in_valid&&in_ready writes in_value to buf[fill_cnt] and increments fill_cnt.
  - input_enable=0; input_index and input_value hold their last values.
  - On the accept that makes fill_cnt reach VECTOR_LENGTH: in_ready drops in the same edge, fill_cnt clears, state goes to STREAM.
  - in_valid low stalls FILL indefinitely with no timeout.
- State STREAM:
  - in_ready=0; in_valid is ignored and no data is lost or written.
  - Each cycle drives input_enable=1, input_index=str_cnt, input_value=buf[str_cnt], then increments str_cnt.
  - Element 0 appears on the outputs in the cycle immediately after the last accept (latency 1 cycle).
  - Exactly VECTOR_LENGTH consecutive enabled cycles, with no gaps.
  - After element VECTOR_LENGTH-1: str_cnt clears, state goes to FLUSH.
- State FLUSH (exactly 1 cycle):
  - input_enable=0, input_index=0, input_value=0, vector_done=1, in_ready=0.
  - Next state is FILL.
  - Minimum vector period is therefore 2*VECTOR_LENGTH+1 cycles.
- Width rules:
  - Counters are INDEX_WIDTH wide and compare with == VECTOR_LENGTH-1; they never wrap past that value.
  - input_index is zero-extended.
- Reset mid-FILL or mid-STREAM:
  - Immediate return to reset values; the partial vector is discarded.
  - vector_done does not pulse for an aborted vector.
  - The next accepted element is stored as index 0.
- A valid/ready handshake on the same edge as the FILL->STREAM transition counts as the final element only. No element is ever accepted in STREAM or FLUSH.
- Back-to-back vectors: upstream holding in_valid high continuously yields the pattern VECTOR_LENGTH accepts, VECTOR_LENGTH enabled outputs, 1 bubble, repeating.

Test Plan:
- Reset with in_valid=0 for 5 cycles -> in_ready=1 from the first edge after release; input_enable=0, vector_done=0 throughout.
- VECTOR_LENGTH=10, feed values 3,7,1,9,9,0,2,8,5,4 with in_valid held high -> starting one cycle after the 10th accept, 10 cycles with input_enable=1 and (index,value)=(0,3),(1,7)..(9,4); then one cycle of input_enable=0 with vector_done=1; then in_ready=1 again.
- Same vector with in_valid toggled 1,0,1,0 -> the same stream order and values; stream starts exactly 1 cycle after the 10th accept.
- in_valid=1 with value 0xFF during STREAM and FLUSH -> in_ready=0; the next vector's element 0 is the first value presented after in_ready returns, not 0xFF.
- reset_n pulsed low on stream element 4 -> input_enable=0 asynchronously, no vector_done pulse; a new 10-element vector then streams from index 0.
- Two vectors back-to-back, second vector 10,20..100 -> vector_done pulses exactly twice, 21 cycles apart; the second stream carries index 9 with value 100.
